// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage drives a byte address; the memory answers combinationally.
interface if_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;

   modport master (output imem_addr, input imem_data);
   modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, reads instruction memory and fills IF/ID.
// state | meaning
// RUN   | fetching; redirect > stall > illegal-PC halt > normal fetch
// HALT  | illegal PC seen; PC held, IF/ID empty, only a redirect restarts fetch
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 512
) (
   input  logic              clk,
   input  logic              reset_n,
   if_stage_if.master        imem,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              id_valid,
   output logic [31:0]       id_instr,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_pc_plus4,
   output logic              fetch_fault,
   output logic [31:0]       fetch_count
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES) - 32'd4;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        id_valid_q;
   logic [31:0] id_instr_q;
   logic [31:0] id_pc_q;
   logic [31:0] id_pc_plus4_q;
   logic        fault_q;
   logic [31:0] count_q;
   logic        illegal;

   // Unsigned compare on the full PC, so high addresses never alias back into range.
   assign illegal        = (pc_q[1:0] != 2'b00) || (pc_q > LAST_WORD);
   assign imem.imem_addr = pc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         id_valid_q    <= 1'b0;
         id_instr_q    <= 32'h0;
         id_pc_q       <= 32'h0;
         id_pc_plus4_q <= 32'h0;
         fault_q       <= 1'b0;
         count_q       <= 32'h0;
      end else begin
         case (state_q)
            RUN: begin
               if (redirect_valid) begin
                  pc_q       <= redirect_pc;
                  id_valid_q <= 1'b0;
                  id_instr_q <= 32'h0;
               end else if (stall) begin
                  pc_q <= pc_q;
               end else if (illegal) begin
                  state_q    <= HALT;
                  fault_q    <= 1'b1;
                  id_valid_q <= 1'b0;
                  id_instr_q <= 32'h0;
               end else begin
                  pc_q          <= pc_q + 32'd4;
                  id_valid_q    <= 1'b1;
                  id_instr_q    <= imem.imem_data;
                  id_pc_q       <= pc_q;
                  id_pc_plus4_q <= pc_q + 32'd4;
                  count_q       <= count_q + 32'd1;
               end
            end
            HALT: begin
               // The new PC is not checked here; RUN re-evaluates it on the next edge.
               if (redirect_valid) begin
                  pc_q    <= redirect_pc;
                  state_q <= RUN;
                  fault_q <= 1'b0;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign id_valid    = id_valid_q;
   assign id_instr    = id_instr_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc_plus4_q;
   assign fetch_fault = fault_q;
   assign fetch_count = count_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS core, directly upstream of the instruction memory.
- Owns the PC and drives the memory's byte address. Memory read is combinational, big-endian, 4 bytes from addr..addr+3.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles stall from hazard logic, redirect/flush from branch/jump resolution, and halts on an illegal fetch address.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_BYTES, 512: instruction memory size in bytes. Legal fetch iff pc[1:0]==0 and pc <= IMEM_BYTES-4.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- imem_addr  out  32  byte address to instruction memory; equals the current PC
- imem_data  in  32  instruction word returned combinationally for imem_addr
- stall  in  1  hold PC and IF/ID contents this cycle
- redirect_valid  in  1  taken branch/jump resolved downstream; load redirect_pc and flush IF/ID
- redirect_pc  in  32  redirect target
- id_valid  out  1  IF/ID holds a valid instruction
- id_instr  out  32  IF/ID instruction word
- id_pc  out  32  address of id_instr
- id_pc_plus4  out  32  id_pc+4, modulo 2^32
- fetch_fault  out  1  sticky; fetch halted on an illegal PC
- fetch_count  out  32  number of instructions delivered to IF/ID

Behaviour:
Reset (reset_n low, asynchronous):
- pc=RESET_PC, state=RUN.
- id_valid=0, id_instr=0 (NOP), id_pc=0, id_pc_plus4=0.
- fetch_fault=0, fetch_count=0.

Datapath:
- imem_addr=pc, combinational; no internal read latency.
- The word at pc is latched into IF/ID at the next rising edge, so an instruction appears at ID one cycle after its PC is driven.
- illegal = (pc[1:0]!=0) | (pc > IMEM_BYTES-4). Evaluate with a 32-bit unsigned compare; no wrap into legal range.

States: RUN, HALT.

RUN, per rising edge, priority highest first:
1. redirect_valid:
   - pc<=redirect_pc.
   - id_valid<=0, id_instr<=0.
   - Overrides stall in the same cycle.
   - fetch_count unchanged.
2. stall:
   - pc and all IF/ID registers hold.
   - fetch_count holds.
3. illegal:
   - state<=HALT, fetch_fault<=1.
   - id_valid<=0, id_instr<=0.
   - pc holds.
4. otherwise:
   - pc<=pc+4, modulo 2^32.
   - id_valid<=1, id_instr<=imem_data.
   - id_pc<=pc, id_pc_plus4<=pc+4.
   - fetch_count<=fetch_count+1, wrapping at 2^32.

HALT:
- pc holds, id_valid=0, fetch_fault=1, stall ignored.
- redirect_valid: pc<=redirect_pc, state<=RUN, fetch_fault<=0. Legality of the new PC is re-checked on the following edge.
- Only redirect or reset exits HALT.

Boundaries:
- Last legal word is IMEM_BYTES-4 (0x1FC at default). Fetching it is normal; the next PC 0x200 faults.
- Redirect to an illegal target is accepted into pc, then faults one edge later with no instruction delivered.
- Reset asserted mid-cycle clears everything immediately, independent of clk.
- First edge after reset deassertion fetches RESET_PC.

Test Plan:
- Reset, memory words 0x20080001, 0x20090010, 0x200a0020 at 0,4,8, 3 free-run edges -> imem_addr 0,4,8,0xC. ID sees instr 0x20080001/pc 0, then 0x20090010/pc 4, then 0x200a0020/pc 8, id_valid=1, fetch_count=3.
- stall held 2 cycles at pc=8 -> imem_addr stays 8, IF/ID holds pc 4 contents, fetch_count frozen. After release, next edge delivers pc 8.
- redirect_valid with redirect_pc=0x18 and stall=1 in the same cycle -> next edge: pc=0x18, id_valid=0, id_instr=0. Following edge: id_pc=0x18, id_valid=1.
- redirect_pc=0x1FC, free-run -> delivers pc 0x1FC. Next edge: fetch_fault=1, id_valid=0, imem_addr held at 0x200 for 5 cycles. Then redirect to 0 -> fault clears, fetch resumes at 0.
- redirect_pc=0x6 (misaligned) -> one edge later fetch_fault=1, no instruction delivered, fetch_count unchanged.
- reset_n pulsed low between edges at pc=0x10 with count=4 -> outputs immediately: id_valid=0, fetch_count=0, imem_addr=RESET_PC, fetch_fault=0.
